// File: rtl/vram_writer.sv
// Purpose: write side of the Lynx video RAM; queues CPU writes and commits them to the four colour banks in slots the video fetch does not own.
// Latency: a request pushed into an empty FIFO is written at the first ce edge with vnext=0 at least one clock after the push.
// Backpressure: cpuWait is high while the FIFO holds DEPTH entries; a wr while full is dropped.
//
// Optional build macro: VRAM_WRITE_OVF_EN -- when defined, ovf counts dropped writes
// (saturating at 255, cleared only by reset); otherwise ovf is tied to zero.
//
// Ports:
//   clock            system clock
//   reset            asynchronous, active-low reset
//   ce               pixel clock enable; each ce edge starts a new memory slot
//   vnext            sampled on ce; 1 = the next slot belongs to the video fetch
//   wr/wa/wd/wbank   CPU write strobe, address, data and 4-bit bank mask
//   cpuWait          FIFO full, CPU must hold off ("wait" is a reserved word in SystemVerilog)
//   mwe/mb/ma/md     registered memory write enable, bank, address and data for the current slot
//   ovf              dropped-write count
module vram_writer #(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic        vnext,
   input  logic        wr,
   input  logic [12:0] wa,
   input  logic [7:0]  wd,
   input  logic [3:0]  wbank,
   output logic        cpuWait,
   output logic        mwe,
   output logic [1:0]  mb,
   output logic [12:0] ma,
   output logic [7:0]  md,
   output logic [7:0]  ovf
);

   localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CntW = PtrW + 1;

   typedef struct packed {
      logic [3:0]  mask;
      logic [12:0] addr;
      logic [7:0]  data;
   } entry_t;

   entry_t          fifoMem [DEPTH];
   entry_t          head;
   logic [PtrW-1:0] wrPtr;
   logic [PtrW-1:0] rdPtr;
   logic [CntW-1:0] count;

   logic            full;
   logic            empty;
   logic            doPush;
   logic            doCommit;
   logic            doPop;
   logic [1:0]      bankSel;
   logic [3:0]      maskLeft;

   assign full    = (count == CntW'(DEPTH));
   assign empty   = (count == '0);
   assign cpuWait = full;

   // Fullness is the registered value, so a wr in the same clock as a pop
   // from a full FIFO is still dropped.
   assign doPush   = wr && (wbank != 4'b0000) && !full;
   assign head     = fifoMem[rdPtr];
   assign doCommit = ce && !vnext && !empty;

   // Lowest remaining bank bit of the head entry is served first.
   always_comb begin
      bankSel = 2'd0;
      if (head.mask[0]) begin
         bankSel = 2'd0;
      end else if (head.mask[1]) begin
         bankSel = 2'd1;
      end else if (head.mask[2]) begin
         bankSel = 2'd2;
      end else if (head.mask[3]) begin
         bankSel = 2'd3;
      end
   end

   always_comb begin
      maskLeft          = head.mask;
      maskLeft[bankSel] = 1'b0;
   end

   assign doPop = doCommit && (maskLeft == 4'b0000);

   // Entry storage needs no reset: count gates every read. A push only
   // targets the head slot when the FIFO is empty, and a commit needs a
   // non-empty FIFO, so the two writes below never hit the same entry.
   always_ff @(posedge clock) begin
      if (doPush) begin
         fifoMem[wrPtr] <= '{mask: wbank, addr: wa, data: wd};
      end
      if (doCommit) begin
         fifoMem[rdPtr].mask <= maskLeft;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + PtrW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + PtrW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

   // Slot outputs change only on ce; address/data/bank hold through
   // video-owned and idle slots, only the write enable drops.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mwe <= 1'b0;
         mb  <= 2'd0;
         ma  <= 13'd0;
         md  <= 8'd0;
      end else if (ce) begin
         if (doCommit) begin
            mwe <= 1'b1;
            mb  <= bankSel;
            ma  <= head.addr;
            md  <= head.data;
         end else begin
            mwe <= 1'b0;
         end
      end
   end

`ifdef VRAM_WRITE_OVF_EN
   logic [7:0] ovfCount;

   // A wr with an empty bank mask is ignored rather than dropped, so it
   // does not count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovfCount <= 8'd0;
      end else if (wr && (wbank != 4'b0000) && full && (ovfCount != 8'hFF)) begin
         ovfCount <= ovfCount + 8'd1;
      end
   end

   assign ovf = ovfCount;
`else
   assign ovf = 8'd0;
`endif

endmodule
